// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit with HI/LO result registers.
//            MULT/MULTU/DIV/DIVU run for a fixed number of cycles on latched
//            operands; MTHI/MTLO write HI/LO directly in a single cycle.
// Options  : MDU_DIV_ZERO_HOLD_EN - when defined, a divide by zero leaves
//            HI/LO untouched; otherwise it writes HI=dividend, LO=all ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic [2:0]  MDUop,
  input  logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] output_hi,
  output logic [31:0] output_lo
);

  // Counter is sized for the longer of the two latencies, never below 4 bits.
  localparam int C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CW_RAW  = $clog2(C_MAX_CYC + 1);
  localparam int C_CW      = (C_CW_RAW < 4) ? 4 : C_CW_RAW;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [C_CW-1:0]   cnt_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [1:0]        op_q;      // [1]=divide, [0]=unsigned
  logic              busy_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;

  logic [63:0]       prod_s;
  logic [63:0]       prod_u;
  logic              neg_a;
  logic              neg_b;
  logic [31:0]       abs_a;
  logic [31:0]       abs_b;
  logic [31:0]       den;
  logic [31:0]       q_mag;
  logic [31:0]       r_mag;
  logic              res_wr_d;
  logic [31:0]       res_hi_d;
  logic [31:0]       res_lo_d;

  assign busy      = busy_q;
  assign stall     = start | busy_q;
  assign output_hi = hi_q;
  assign output_lo = lo_q;

  // Result datapath: works only from the latched operands, so inputs may change during RUN.
  always_comb begin
    prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    // Division is done on magnitudes so that 0x80000000 / -1 wraps cleanly.
    neg_a    = ~op_q[0] & a_q[31];
    neg_b    = ~op_q[0] & b_q[31];
    abs_a    = neg_a ? (32'd0 - a_q) : a_q;
    abs_b    = neg_b ? (32'd0 - b_q) : b_q;
    den      = (abs_b == 32'd0) ? 32'd1 : abs_b;
    q_mag    = abs_a / den;
    r_mag    = abs_a % den;
    res_wr_d = 1'b1;
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    if (!op_q[1]) begin
      res_hi_d = op_q[0] ? prod_u[63:32] : prod_s[63:32];
      res_lo_d = op_q[0] ? prod_u[31:0]  : prod_s[31:0];
    end else if (b_q == 32'd0) begin
`ifdef MDU_DIV_ZERO_HOLD_EN
      res_wr_d = 1'b0;
`else
      res_hi_d = a_q;
      res_lo_d = 32'hFFFF_FFFF;
`endif
    end else begin
      res_lo_d = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
      res_hi_d = neg_a ? (32'd0 - r_mag) : r_mag;
    end
  end

  // Control FSM plus HI/LO registers; reset aborts any operation without a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (MDUop)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                a_q     <= input1;
                b_q     <= input2;
                op_q    <= MDUop[1:0];
                cnt_q   <= MDUop[1] ? C_CW'(DIV_CYCLES - 1) : C_CW'(MULT_CYCLES - 1);
                busy_q  <= 1'b1;
                state_q <= S_RUN;
              end
              3'b100:  hi_q <= input1;
              3'b101:  lo_q <= input1;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // start is ignored here; upstream stalls on the stall output.
          if (cnt_q == '0) begin
            if (res_wr_d) begin
              hi_q <= res_hi_d;
              lo_q <= res_lo_d;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit: arithmetic reference model,
//            per-cycle output compare and directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] input1 = 32'd0;
  logic [31:0] input2 = 32'd0;
  logic [2:0]  MDUop = 3'd0;
  logic        start = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] output_hi;
  logic [31:0] output_lo;

  int errors = 0;
  int checks = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .input1    (input1),
    .input2    (input2),
    .MDUop     (MDUop),
    .start     (start),
    .busy      (busy),
    .stall     (stall),
    .output_hi (output_hi),
    .output_lo (output_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {write, hi, lo}.
  function automatic logic [64:0] calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin q = sa * sb; return {1'b1, 64'(q)}; end
      2'd1: begin pu = 64'(a) * 64'(b); return {1'b1, pu}; end
      default: begin
        if (b == 32'd0) begin
`ifdef MDU_DIV_ZERO_HOLD_EN
          return {1'b0, 64'd0};
`else
          return {1'b1, a, 32'hFFFF_FFFF};
`endif
        end
        if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {1'b1, 32'(r), 32'(q)};
        end
        return {1'b1, a % b, a / b};
      end
    endcase
  endfunction

  // Behavioural model: a countdown of remaining busy cycles and a pending result.
  logic        m_busy = 1'b0;
  int          m_rem  = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        p_wr = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_rem  <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        if (p_wr) begin
          m_hi <= p_hi;
          m_lo <= p_lo;
        end
      end
      m_rem <= m_rem - 1;
    end else if (start) begin
      if (MDUop <= 3'd3) begin
        {p_wr, p_hi, p_lo} <= calc(MDUop[1:0], input1, input2);
        m_busy <= 1'b1;
        m_rem  <= MDUop[1] ? DC : MC;
      end else if (MDUop == 3'd4) begin
        m_hi <= input1;
      end else if (MDUop == 3'd5) begin
        m_lo <= input1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("cyc_stall", {31'd0, stall}, {31'd0, start | m_busy});
    chk("cyc_hi", output_hi, m_hi);
    chk("cyc_lo", output_lo, m_lo);
  end

  // Length of the most recent busy run.
  int run_cnt = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (busy) run_cnt <= run_cnt + 1;
    else if (run_cnt != 0) begin
      last_run <= run_cnt;
      run_cnt  <= 0;
    end
  end

  // Callers are positioned between a negedge and the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    MDUop  = op;
    input1 = a;
    input2 = b;
    @(negedge clk);
    #1;
    start  = 1'b0;
    input1 = $urandom;
    input2 = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    #2;
    chk("done_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", output_hi, 32'd0);
    chk("rst_lo", output_lo, 32'd0);
    reset = 1'b0;

    // Signed and unsigned multiply.
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done();
    chk("mult_len", last_run, MC);
    chk("mult_hi", output_hi, 32'hFFFF_FFFF);
    chk("mult_lo", output_lo, 32'hFFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done();
    chk("multu_hi", output_hi, 32'h0000_0002);
    chk("multu_lo", output_lo, 32'hFFFF_FFFA);

    // Signed and unsigned divide.
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    chk("div_len", last_run, DC);
    chk("div_lo", output_lo, 32'hFFFF_FFFD);
    chk("div_hi", output_hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2);
    wait_done();
    chk("divu_lo", output_lo, 32'd3);
    chk("divu_hi", output_hi, 32'd1);

    // MTHI then MTLO back to back.
    start = 1'b1; MDUop = 3'd4; input1 = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_hi", output_hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_stall", {31'd0, stall}, 32'd1);
    #1;
    MDUop = 3'd5; input1 = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("mtlo_lo", output_lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", output_hi, 32'h1234_5678);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("mt_stall_off", {31'd0, stall}, 32'd0);
    #1;

    // Start during RUN is ignored.
    issue(3'd0, 32'h0000_1234, 32'h0000_0010);
    @(negedge clk);
    #1;
    start = 1'b1; MDUop = 3'd2; input1 = 32'd1000; input2 = 32'd3;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done();
    chk("ovl_len", last_run, MC);
    chk("ovl_hi", output_hi, 32'd0);
    chk("ovl_lo", output_lo, 32'h0001_2340);

    // Signed overflow divide.
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    chk("divov_lo", output_lo, 32'h8000_0000);
    chk("divov_hi", output_hi, 32'd0);

    // Reserved opcodes do nothing.
    start = 1'b1; MDUop = 3'd6; input1 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rsv6_busy", {31'd0, busy}, 32'd0);
    #1;
    MDUop = 3'd7;
    @(negedge clk);
    chk("rsv7_hi", output_hi, 32'd0);
    chk("rsv7_lo", output_lo, 32'h8000_0000);
    #1;
    start = 1'b0;

    // Divide by zero with preloaded HI/LO.
    start = 1'b1; MDUop = 3'd4; input1 = 32'h11;
    @(negedge clk);
    #1;
    MDUop = 3'd5; input1 = 32'h22;
    @(negedge clk);
    #1;
    start = 1'b0;
    issue(3'd2, 32'h55, 32'd0);
    wait_done();
    chk("dz_len", last_run, DC);
`ifdef MDU_DIV_ZERO_HOLD_EN
    chk("dz_hi", output_hi, 32'h11);
    chk("dz_lo", output_lo, 32'h22);
`else
    chk("dz_hi", output_hi, 32'h55);
    chk("dz_lo", output_lo, 32'hFFFF_FFFF);
`endif

    // Asynchronous reset mid-divide, then immediate restart.
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", output_hi, 32'd0);
    chk("arst_lo", output_lo, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    issue(3'd0, 32'd3, 32'd4);
    wait_done();
    chk("post_rst_len", last_run, MC);
    chk("post_rst_lo", output_lo, 32'd12);
    chk("post_rst_hi", output_hi, 32'd0);

    // Extra corners, mostly checked by the model.
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done();
    chk("mult_min_hi", output_hi, 32'h4000_0000);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    chk("multu_max_hi", output_hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", output_lo, 32'd1);
    issue(3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    wait_done();
    chk("div_nn_lo", output_lo, 32'd3);
    chk("div_nn_hi", output_hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'h1234_5678, 32'd0);
    wait_done();
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port input1, input, 32, operand A (rs value from the E stage, same source as the ALU input1).
REQ-006 SHALL have port input2, input, 32, operand B (rt value from the E stage).
REQ-007 SHALL have port MDUop, input, 3, operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-008 SHALL have port start, input, 1, one-cycle launch strobe qualifying MDUop.
REQ-009 SHALL have port busy, output, 1, registered; high while an operation is in flight.
REQ-010 SHALL have port stall, output, 1, combinational (start | busy) for the hazard unit.
REQ-011 SHALL have port output_hi, output, 32, registered HI.
REQ-012 SHALL have port output_lo, output, 32, registered LO.

Function
REQ-013 SHALL use two states, IDLE and RUN, with a cycle counter of at least 4 bits.
REQ-014 In IDLE, start=1 at edge k with MDUop in 000-011 SHALL latch input1, input2 and MDUop and enter RUN, with busy=1 from after edge k.
REQ-015 RUN SHALL last MULT_CYCLES (multiply) or DIV_CYCLES (divide) edges; at edge k+N it SHALL write HI/LO, clear busy and return to IDLE.
REQ-016 In IDLE, start=1 with MTHI (MTLO) SHALL write input1 into HI (LO) at that edge, with busy staying 0 and the other register unchanged.
REQ-017 start=1 with MDUop 110/111 SHALL be ignored: no state change.
REQ-018 start=1 while busy=1 SHALL be ignored; upstream is required to stall using the stall output.
REQ-019 MULT SHALL form the signed 64-bit product; MULTU the unsigned product; HI=[63:32], LO=[31:0].
REQ-020 DIV/DIVU SHALL set LO=quotient truncated toward zero and HI=remainder with the sign of the dividend.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Operand changes during RUN SHALL NOT affect the result; the latched copies are used.
REQ-023 output_hi and output_lo SHALL hold their old values throughout RUN and update only at the completing edge.

Reset
REQ-024 reset=1 SHALL immediately, without a clock, force IDLE, busy=0, counter=0, output_hi=0 and output_lo=0.
REQ-025 reset asserted mid-RUN SHALL abort the operation with no HI/LO write; after release, the block SHALL accept start on the first edge.

Configuration
REQ-026 Macro MDU_DIV_ZERO_HOLD_EN defined: DIV/DIVU with input2=0 SHALL still run DIV_CYCLES with busy high, then leave HI/LO unchanged.
REQ-027 Macro MDU_DIV_ZERO_HOLD_EN undefined: DIV/DIVU with input2=0 SHALL write HI=input1 and LO=0xFFFFFFFF at completion.

Verification
REQ-028 MULT input1=0xFFFFFFFE (-2), input2=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 DIV input1=-7, input2=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-030 MTHI input1=0x12345678, then MTLO input1=0x9ABCDEF0 on the next cycle -> both registers updated one edge after each start, busy stays 0, stall is high only during the start cycles.
REQ-031 Start MULT, then pulse start with DIV and new operands at cycle 2 of RUN -> second start ignored; result is the original MULT; busy falls after exactly 5 cycles.
REQ-032 Start DIV, assert reset at cycle 4 asynchronously -> busy=0 and HI=LO=0 before the next edge; next start MULT 3*4 -> LO=12.
REQ-033 DIV by 0 with HI=0x11, LO=0x22 preloaded -> 0x11/0x22 retained with MDU_DIV_ZERO_HOLD_EN defined; HI=input1, LO=0xFFFFFFFF without it.
